decoder_2to4_pulse: RTL and testbench

- Sequential 2-to-4 decoder, the receive-side counterpart of the team's 4-to-2 encoder.
- Accepts a 2-bit code over a valid/ready handshake and drives the matching one-hot line for a fixed pulse length.
- Enforces an idle gap between pulses and keeps a running count of decoded events.
- Sits downstream of the encoder path, converting encoded indices back into line strobes.

---
 rtl/decoder_2to4_pulse.sv | 117 +++++++++++
 tb/tb_decoder_2to4_pulse.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2to4_pulse.sv
// decoder_2to4_pulse
// Sequential 2-to-4 decoder. A 2-bit code is accepted over a valid/ready
// handshake and expanded to a one-hot line. The line is held for PULSE_LEN
// cycles and is followed by GAP_LEN forced idle cycles. A running count of
// accepted codes is kept modulo 2^CNT_W.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     in_code is presented
//   in_ready     block can accept a code this cycle (IDLE and not in reset)
//   in_code      encoded index 0..3
//   out          one-hot decoded line, all-zero when no pulse is active
//   out_valid    high while out carries a pulse
//   busy         high in ACTIVE or GAP
//   count_total  number of accepted codes, modulo 2^CNT_W
module decoder_2to4_pulse #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  output logic [3:0]       out,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] count_total
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  // Timer reload values. The timer counts down to zero, so a phase lasting
  // N cycles is loaded with N-1. GAP_LEN=0 skips the GAP state entirely,
  // so its reload value is never used in that case.
  localparam logic [7:0] PULSE_TMR = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_TMR   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [7:0]       r_timer;
  logic [3:0]       r_out;
  logic             r_out_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;

  // Ready is forced low during reset, so a code presented together with
  // rst can never be accepted.
  assign in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= 8'd0;
      r_out       <= 4'b0000;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_out       <= 4'b0001 << in_code;
            r_out_valid <= 1'b1;
            r_state     <= S_ACTIVE;
            r_busy      <= 1'b1;
            r_timer     <= PULSE_TMR;
            r_count     <= r_count + CNT_ONE;
          end
        end
        S_ACTIVE: begin
          if (r_timer == 8'd0) begin
            r_out       <= 4'b0000;
            r_out_valid <= 1'b0;
            if (GAP_LEN > 0) begin
              r_state <= S_GAP;
              r_timer <= GAP_TMR;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        S_GAP: begin
          if (r_timer == 8'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean idle state.
          r_state     <= S_IDLE;
          r_timer     <= 8'd0;
          r_out       <= 4'b0000;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign count_total = r_count;

endmodule

// File: tb/tb_decoder_2to4_pulse.sv
module tb_decoder_2to4_pulse;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters (PULSE_LEN=4, GAP_LEN=1, CNT_W=8)
  logic       rst, vld, rdy, ov, bsy;
  logic [1:0] code;
  logic [3:0] dout;
  logic [7:0] cnt;

  decoder_2to4_pulse #(.PULSE_LEN(4), .GAP_LEN(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(vld), .in_ready(rdy), .in_code(code),
    .out(dout), .out_valid(ov), .busy(bsy), .count_total(cnt)
  );

  // DUT B: wrap / zero-gap configuration
  logic       rst2, vld2, rdy2, ov2, bsy2;
  logic [1:0] code2;
  logic [3:0] dout2;
  logic [1:0] cnt2;

  decoder_2to4_pulse #(.PULSE_LEN(1), .GAP_LEN(0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst2), .in_valid(vld2), .in_ready(rdy2), .in_code(code2),
    .out(dout2), .out_valid(ov2), .busy(bsy2), .count_total(cnt2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected one-hot pushed when an accept is driven, popped
  // when out_valid rises on DUT A.
  logic [3:0] sb[$];
  logic       prev_ov = 1'b0;
  logic [3:0] cur_exp = 4'b0000;

  always @(negedge clk) begin
    if (ov && !prev_ov) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        cur_exp = sb.pop_front();
        chk("sb_pulse_out", {28'd0, dout}, {28'd0, cur_exp});
      end
    end else if (ov) begin
      chk("sb_hold_out", {28'd0, dout}, {28'd0, cur_exp});
    end
    if (ov) chk("onehot", {31'd0, $onehot(dout)}, 32'd1);
    else    chk("idle_zero", {28'd0, dout}, 32'd0);
    prev_ov = ov;
  end

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] code;
    logic       acc;
    logic [3:0] e_out;
    logic       e_ov;
    logic       e_busy;
    logic       e_rdy;
    logic [7:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] c,
                              input logic a, input logic [3:0] o, input logic eov,
                              input logic eb, input logic er, input logic [7:0] ec);
    vec_t t;
    t.rst = r; t.vld = v; t.code = c; t.acc = a; t.e_out = o;
    t.e_ov = eov; t.e_busy = eb; t.e_rdy = er; t.e_cnt = ec;
    return t;
  endfunction

  vec_t tbl[9];

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; code = 2'd0;
    rst2 = 1'b1; vld2 = 1'b0; code2 = 2'd0;

    // Reset with valid asserted, release, then a single code-2 pulse.
    // Each row: inputs applied before the edge, outputs checked after it.
    tbl[0] = mk(1, 1, 2, 0, 4'b0000, 0, 0, 0, 8'd0);
    tbl[1] = mk(1, 1, 2, 0, 4'b0000, 0, 0, 0, 8'd0);
    tbl[2] = mk(0, 0, 0, 0, 4'b0000, 0, 0, 1, 8'd0);
    tbl[3] = mk(0, 1, 2, 1, 4'b0100, 1, 1, 0, 8'd1);
    tbl[4] = mk(0, 0, 0, 0, 4'b0100, 1, 1, 0, 8'd1);
    tbl[5] = mk(0, 0, 0, 0, 4'b0100, 1, 1, 0, 8'd1);
    tbl[6] = mk(0, 0, 0, 0, 4'b0100, 1, 1, 0, 8'd1);
    tbl[7] = mk(0, 0, 0, 0, 4'b0000, 0, 1, 0, 8'd1);
    tbl[8] = mk(0, 0, 0, 0, 4'b0000, 0, 0, 1, 8'd1);

    #1;
    tick();
    rst2 = 1'b0;

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; vld = tbl[i].vld; code = tbl[i].code;
      if (tbl[i].acc) sb.push_back(4'b0001 << tbl[i].code);
      tick();
      chk($sformatf("t%0d_out", i),  {28'd0, dout}, {28'd0, tbl[i].e_out});
      chk($sformatf("t%0d_ov", i),   {31'd0, ov},   {31'd0, tbl[i].e_ov});
      chk($sformatf("t%0d_busy", i), {31'd0, bsy},  {31'd0, tbl[i].e_busy});
      chk($sformatf("t%0d_rdy", i),  {31'd0, rdy},  {31'd0, tbl[i].e_rdy});
      chk($sformatf("t%0d_cnt", i),  {24'd0, cnt},  {24'd0, tbl[i].e_cnt});
    end

    // All codes back-to-back with in_valid held: accepts every 6 edges.
    // in_code moves on right after each accept and must not disturb out.
    do_reset();
    vld = 1'b1; code = 2'd0;
    for (int k = 0; k < 24; k++) begin
      if (k % 6 == 0) begin
        code = 2'(k / 6);
        sb.push_back(4'b0001 << code);
      end
      chk($sformatf("b2b_rdy_k%0d", k), {31'd0, rdy}, {31'd0, (k % 6 == 0)});
      tick();
      if (k % 6 == 0) code = 2'(k / 6 + 1);
      chk($sformatf("b2b_out_k%0d", k), {28'd0, dout},
          (k % 6 < 4) ? (32'd1 << (k / 6)) : 32'd0);
      chk($sformatf("b2b_cnt_k%0d", k), {24'd0, cnt}, 32'(k / 6 + 1));
    end
    vld = 1'b0;
    chk("b2b_final_cnt", {24'd0, cnt}, 32'd4);

    // Ignore while busy: code 3 presented during code-1 pulse and gap.
    do_reset();
    vld = 1'b1; code = 2'd1;
    sb.push_back(4'b0010);
    tick();
    code = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("ign_cnt_e%0d", k), {24'd0, cnt}, 32'd1);
      chk($sformatf("ign_out_e%0d", k), {28'd0, dout}, (k <= 3) ? 32'h2 : 32'h0);
    end
    chk("ign_rdy_idle", {31'd0, rdy}, 32'd1);
    sb.push_back(4'b1000);
    tick();
    vld = 1'b0;
    chk("ign_accept3_out", {28'd0, dout}, 32'h8);
    chk("ign_accept3_cnt", {24'd0, cnt}, 32'd2);

    // Reset two cycles into a code-0 pulse.
    do_reset();
    vld = 1'b1; code = 2'd0;
    sb.push_back(4'b0001);
    tick();
    vld = 1'b0;
    tick();
    tick();
    chk("mid_pre_out", {28'd0, dout}, 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_out",  {28'd0, dout}, 32'd0);
    chk("mid_ov",   {31'd0, ov},   32'd0);
    chk("mid_busy", {31'd0, bsy},  32'd0);
    chk("mid_cnt",  {24'd0, cnt},  32'd0);
    chk("mid_rdy_in_rst", {31'd0, rdy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rdy_release", {31'd0, rdy}, 32'd1);
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // DUT B: 5 consecutive accepts, 2 edges apart, counter wraps.
    vld2 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) code2 = 2'((k / 2) % 4);
      chk($sformatf("wrap_rdy_k%0d", k), {31'd0, rdy2}, {31'd0, (k % 2 == 0)});
      tick();
      chk($sformatf("wrap_out_k%0d", k), {28'd0, dout2},
          (k % 2 == 0) ? (32'd1 << ((k / 2) % 4)) : 32'd0);
      chk($sformatf("wrap_ov_k%0d", k), {31'd0, ov2}, {31'd0, (k % 2 == 0)});
      chk($sformatf("wrap_cnt_k%0d", k), {30'd0, cnt2}, 32'((k / 2 + 1) % 4));
    end
    vld2 = 1'b0;
    chk("wrap_final_cnt", {30'd0, cnt2}, 32'd1);
    chk("wrap_idle_busy", {31'd0, bsy2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
